xbar_serial_rx: RTL and testbench
=================================

Name: xbar_serial_rx

Overview:
Per-lane serial frame receiver sitting directly downstream of the 8x8 crossbar; one instance per serial_out lane. Samples the lane's serial bit stream on a bit-strobe, detects the start bit, and deserializes destination, source, payload and parity fields. Checks parity and routing. Buffers good frames in a 4-entry FIFO presented on a valid/ready parallel interface. Keeps frame/error statistics for the bench and status logic.

Parameters:
LANE_ID, 0, crossbar output port this instance serves (0..7); compared with the received dst field
DATA_W, 8, payload width in bits
FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
bit_en  input  1  one-cycle strobe marking a valid serial bit period; serial_in is ignored when 0
serial_in  input  1  crossbar serial_out lane; idle level 0
out_valid  output  1  FIFO head holds a frame
out_ready  input  1  consumer accepts head when out_valid && out_ready
out_src  output  3  source port of head frame
out_data  output  DATA_W  payload of head frame
busy  output  1  receiver not in IDLE
frame_cnt  output  8  good frames pushed, saturating at 255
err_cnt  output  8  parity + misroute errors, saturating at 255
ovf  output  1  sticky: good frame dropped because FIFO full; cleared only by rst

Behaviour:
- Frame on the wire, MSB first, one bit per bit_en: start(1) | dst[2:0] | src[2:0] | data[DATA_W-1:0] | par; total 8+DATA_W bits (16 by default).
- Parity is even: the count of ones over dst, src, data and par is even.
- Reset (async, immediate): state=IDLE, FIFO empty, out_valid=0, out_src=0, out_data=0, busy=0, frame_cnt=0, err_cnt=0, ovf=0. Reset mid-frame discards the partial frame.
- FSM states: IDLE, DST, SRC, DATA, PAR. No transitions occur on cycles with bit_en=0.
  - IDLE: on bit_en with serial_in=1, go to DST. A 0 stays in IDLE.
  - DST: after 3 bits, go to SRC.
  - SRC: after 3 bits, go to DATA.
  - DATA: after DATA_W bits, go to PAR. A bit counter is reloaded on each field entry.
  - PAR: on bit_en, sample par, evaluate the frame, return to IDLE. A start bit can be accepted on the very next bit_en.
- Evaluation on the PAR-sampling edge, in priority order:
  1. Parity fail: err_cnt+1, frame dropped.
  2. dst != LANE_ID: err_cnt+1, frame dropped. Only one increment per frame even if both errors apply.
  3. Otherwise: push {src,data} into the FIFO, frame_cnt+1.
- FIFO full at push time: the frame is dropped, ovf=1, frame_cnt is not incremented. Exception: a pop on the same edge makes room, so the push succeeds.
- Latency: out_valid rises on the cycle after the PAR-sampling edge when the FIFO was empty, i.e. the head is registered. out_src/out_data are stable while out_valid=1 && !out_ready.
- Pop occurs on out_valid && out_ready. Simultaneous push and pop keep the count unchanged. Pop when empty is ignored.
- Counters saturate at 255 and do not wrap.
- Pointers wrap modulo FIFO_DEPTH; full/empty are derived from a count of width clog2(FIFO_DEPTH)+1.
- busy = (state != IDLE).

Test Plan:
- LANE_ID=2, bit_en every 4th clk, send 1 010 101 10100101 1 with out_ready=1 -> one beat with out_src=5, out_data=0xA5; frame_cnt=1, err_cnt=0; out_valid rises 1 clk after the 16th bit_en.
- Same frame with par=0 -> no out_valid, err_cnt=1, frame_cnt=0. Then dst=011 with correct parity -> err_cnt=2, nothing pushed.
- out_ready=0, send 5 good frames with data 0x01..0x05 -> FIFO holds 0x01..0x04, ovf=1, frame_cnt=4. Then out_ready=1 -> beats 0x01,0x02,0x03,0x04 in order.
- FIFO full with out_ready pulsed on the exact PAR-sampling edge of a 5th frame (0x55) -> 0x01 popped, 0x55 pushed, ovf stays 0, frame_cnt=5.
- Assert rst in the DATA state, release, then send a good frame -> partial frame discarded, all outputs 0 during reset, next frame received normally.
- Back-to-back frames with no idle bits, bit_en every clk -> both received, busy drops for at most 0 bit periods between frames.

Source files
------------

// File: rtl/xbar_serial_rx.sv
// Per-lane serial frame receiver for one crossbar output lane.
// Deserializes start|dst|src|data|par frames, checks them, and queues good frames in a small valid/ready FIFO.
module xbar_serial_rx #(
    parameter int unsigned LANE_ID    = 0,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              serial_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_src,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic [7:0]        err_cnt,
    output logic              ovf
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BIT_W   = $clog2((DATA_W > 3) ? DATA_W : 3);
    localparam int unsigned HDR_W   = 6 + DATA_W;
    localparam int unsigned ENTRY_W = 3 + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DST,
        S_SRC,
        S_DATA,
        S_PAR
    } state_e;

    typedef logic [ENTRY_W-1:0] entry_t;

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [HDR_W-1:0]   shift_q, shift_d;
    logic               par_acc_q, par_acc_d;
    logic               busy_q, busy_d;

    entry_t             mem_q [FIFO_DEPTH];
    entry_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic [2:0]         out_src_q, out_src_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               ovf_q, ovf_d;

    logic               frame_done;
    logic               par_ok;
    logic               lane_ok;
    logic               frame_good;
    logic               frame_err;
    logic [2:0]         rx_dst;
    logic [2:0]         rx_src;
    logic [DATA_W-1:0]  rx_data;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               drop;
    entry_t             head;

    // Frame deserializer: one field per state, bit counter counts down to the field's last bit
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        frame_done = 1'b0;

        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (serial_in) begin
                        state_d   = S_DST;
                        bit_cnt_d = BIT_W'(2);
                        par_acc_d = 1'b0;
                    end
                end
                S_DST: begin
                    shift_d   = {shift_q[HDR_W-2:0], serial_in};
                    par_acc_d = par_acc_q ^ serial_in;
                    if (bit_cnt_q == '0) begin
                        state_d   = S_SRC;
                        bit_cnt_d = BIT_W'(2);
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end
                S_SRC: begin
                    shift_d   = {shift_q[HDR_W-2:0], serial_in};
                    par_acc_d = par_acc_q ^ serial_in;
                    if (bit_cnt_q == '0) begin
                        state_d   = S_DATA;
                        bit_cnt_d = BIT_W'(DATA_W - 1);
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end
                S_DATA: begin
                    shift_d   = {shift_q[HDR_W-2:0], serial_in};
                    par_acc_d = par_acc_q ^ serial_in;
                    if (bit_cnt_q == '0) begin
                        state_d = S_PAR;
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end
                S_PAR: begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // Frame check on the parity-sampling edge; a parity error masks the lane check
    always_comb begin
        rx_dst     = shift_q[HDR_W-1 -: 3];
        rx_src     = shift_q[DATA_W +: 3];
        rx_data    = shift_q[DATA_W-1:0];
        par_ok     = ((par_acc_q ^ serial_in) == 1'b0);
        lane_ok    = (rx_dst == 3'(LANE_ID));
        frame_good = frame_done && par_ok && lane_ok;
        frame_err  = frame_done && !(par_ok && lane_ok);
    end

    // FIFO control; a same-edge pop frees the slot for a push into a full FIFO
    always_comb begin
        pop       = out_valid_q && out_ready;
        fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
        push      = frame_good && (!fifo_full || pop);
        drop      = frame_good && fifo_full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {rx_src, rx_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // Head is registered from the next-state FIFO view so it is valid the cycle after a push
        head        = mem_d[rd_ptr_d];
        out_valid_d = (count_d != '0);
        out_src_d   = head[ENTRY_W-1 -: 3];
        out_data_d  = head[DATA_W-1:0];
    end

    // Saturating statistics and sticky overflow
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        ovf_d       = ovf_q | drop;
        if (push && (frame_cnt_q != 8'hFF)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (frame_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_acc_q   <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            out_data_q  <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_acc_q   <= par_acc_d;
            busy_q      <= busy_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            out_data_q  <= out_data_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_xbar_serial_rx.sv
// Directed bench for xbar_serial_rx on lane 2: reception, error drops, overflow,
// pop-on-push-edge, mid-frame reset and back-to-back frames.
module tb_xbar_serial_rx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LANE   = 2;

    logic              clk;
    logic              rst;
    logic              bit_en;
    logic              serial_in;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_src;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic [7:0]        frame_cnt;
    logic [7:0]        err_cnt;
    logic              ovf;

    int n_checks;
    int n_fail;
    logic [10:0] rx_q[$];

    xbar_serial_rx #(
        .LANE_ID   (LANE),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_en   (bit_en),
        .serial_in(serial_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_src  (out_src),
        .out_data (out_data),
        .busy     (busy),
        .frame_cnt(frame_cnt),
        .err_cnt  (err_cnt),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted beat as {src, data}
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) rx_q.push_back({out_src, out_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk_frame(input logic [2:0] d, input logic [2:0] s,
                                             input logic [7:0] data, input logic bad_par);
        logic par;
        par = (^{d, s, data}) ^ bad_par;
        return {1'b1, d, s, data, par};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bit_en    = 1'b0;
            serial_in = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        @(posedge clk); #1;
        bit_en    = 1'b1;
        serial_in = b;
        idle(gap);
    endtask

    task automatic send_frame(input logic [2:0] d, input logic [2:0] s, input logic [7:0] data,
                              input logic bad_par, input int gap, input bit pulse);
        logic [15:0] f;
        f = mk_frame(d, s, data, bad_par);
        for (int i = 15; i >= 1; i--) send_bit(f[i], gap);
        @(posedge clk); #1;
        bit_en    = 1'b1;
        serial_in = f[0];
        if (pulse) out_ready = 1'b1;
        @(posedge clk); #1;
        bit_en    = 1'b0;
        serial_in = 1'b0;
        if (pulse) out_ready = 1'b0;
        idle((gap > 0) ? gap - 1 : 0);
    endtask

    task automatic wait_beats(input int n, input string tag);
        for (int c = 0; c < 400; c++) begin
            if (rx_q.size() >= n) break;
            @(posedge clk);
        end
        check(tag, rx_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] f;
        logic [31:0] stream;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bit_en    = 1'b0;
        serial_in = 1'b0;
        out_ready = 1'b1;

        #1;
        check("rst_state", {out_valid, out_src, out_data, busy, frame_cnt, err_cnt, ovf}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Good frame: valid rises the cycle after the parity-sampling edge
        f = mk_frame(3'd2, 3'd5, 8'hA5, 1'b0);
        check("t1_par_bit", f[0], 1);
        for (int i = 15; i >= 1; i--) send_bit(f[i], 3);
        @(posedge clk); #1;
        bit_en    = 1'b1;
        serial_in = f[0];
        check("t1_valid_pre", out_valid, 0);
        check("t1_busy", busy, 1);
        @(posedge clk); #1;
        bit_en    = 1'b0;
        serial_in = 1'b0;
        check("t1_valid", out_valid, 1);
        check("t1_src", out_src, 5);
        check("t1_data", out_data, 8'hA5);
        check("t1_frames", frame_cnt, 1);
        check("t1_errs", err_cnt, 0);
        idle(4);
        check("t1_beats", rx_q.size(), 1);
        if (rx_q.size() > 0) check("t1_beat0", rx_q[0], {3'd5, 8'hA5});
        check("t1_drained", out_valid, 0);

        // Parity error then misroute: counted once each, nothing pushed
        rx_q.delete();
        send_frame(3'd2, 3'd5, 8'hA5, 1'b1, 3, 0);
        check("t2_par_errs", err_cnt, 1);
        check("t2_par_valid", out_valid, 0);
        send_frame(3'd3, 3'd5, 8'hA5, 1'b0, 3, 0);
        check("t2_route_errs", err_cnt, 2);
        check("t2_frames", frame_cnt, 1);
        idle(4);
        check("t2_beats", rx_q.size(), 0);

        // Overflow: fifth good frame dropped while the consumer stalls
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(3'd2, 3'd3, 8'(k), 1'b0, 3, 0);
        check("t3_frames", frame_cnt, 5);
        check("t3_ovf", ovf, 1);
        check("t3_head_valid", out_valid, 1);
        check("t3_head_data", out_data, 8'h01);
        check("t3_head_stable", out_data, 8'h01);
        rx_q.delete();
        out_ready = 1'b1;
        wait_beats(4, "t3_beats");
        idle(6);
        check("t3_no_extra", rx_q.size(), 4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++) check("t3_order", rx_q[i], {3'd3, 8'(i + 1)});

        // Reset mid-DATA discards the partial frame and clears everything
        rx_q.delete();
        f = mk_frame(3'd2, 3'd6, 8'h77, 1'b0);
        for (int i = 15; i >= 5; i--) send_bit(f[i], 3);
        check("t5_busy_pre", busy, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_rst_outs", {out_valid, out_src, out_data, busy, frame_cnt, err_cnt, ovf}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        send_frame(3'd2, 3'd6, 8'h77, 1'b0, 3, 0);
        wait_beats(1, "t5_beats");
        if (rx_q.size() > 0) check("t5_beat", rx_q[0], {3'd6, 8'h77});
        check("t5_frames", frame_cnt, 1);
        check("t5_errs", err_cnt, 0);

        // Full FIFO with a pop on the same edge as the fifth push
        idle(4);
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(3'd2, 3'd1, 8'(k), 1'b0, 3, 0);
        check("t4_frames_full", frame_cnt, 5);
        rx_q.delete();
        send_frame(3'd2, 3'd1, 8'h55, 1'b0, 3, 1);
        check("t4_frames", frame_cnt, 6);
        check("t4_ovf", ovf, 0);
        check("t4_popped", rx_q.size(), 1);
        if (rx_q.size() > 0) check("t4_pop_beat", rx_q[0], {3'd1, 8'h01});
        check("t4_head", out_data, 8'h02);
        out_ready = 1'b1;
        wait_beats(5, "t4_beats");
        if (rx_q.size() >= 5) begin
            check("t4_b1", rx_q[1], {3'd1, 8'h02});
            check("t4_b2", rx_q[2], {3'd1, 8'h03});
            check("t4_b3", rx_q[3], {3'd1, 8'h04});
            check("t4_b4", rx_q[4], {3'd1, 8'h55});
        end

        // Back-to-back frames, bit_en every clock, no idle bits between them
        idle(4);
        rx_q.delete();
        stream = {mk_frame(3'd2, 3'd4, 8'h3C, 1'b0), mk_frame(3'd2, 3'd7, 8'hC3, 1'b0)};
        for (int i = 31; i >= 0; i--) begin
            send_bit(stream[i], 0);
            if (i == 24) check("t6_busy_mid", busy, 1);
        end
        idle(1);
        wait_beats(2, "t6_beats");
        if (rx_q.size() >= 2) begin
            check("t6_b0", rx_q[0], {3'd4, 8'h3C});
            check("t6_b1", rx_q[1], {3'd7, 8'hC3});
        end
        check("t6_frames", frame_cnt, 8);
        check("t6_errs", err_cnt, 0);
        check("t6_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
